// File: rtl/ehgu_clk2phase_pkg.sv
// Shared types and helpers for the two-phase non-overlapping clock controller.
package ehgu_clk2phase_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P0     = 3'd1,
    DEAD01 = 3'd2,
    P1     = 3'd3,
    DEAD10 = 3'd4
  } ehgu_c2p_state_t;

  // Widest count the clamp helper handles; callers narrow the result back down.
  localparam int C2P_MAX_W = 32;

  // A zero count becomes 1 unless zero is a legal value for that count.
  function automatic logic [C2P_MAX_W-1:0] c2p_clamp(input logic [C2P_MAX_W-1:0] cnt,
                                                     input logic                 allow_zero);
    if (cnt == '0) begin
      return allow_zero ? '0 : C2P_MAX_W'(1);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ehgu_clk2phase_ctrl_counter.sv
// Loadable down-counter with a zero flag; sits at zero until reloaded.
module ehgu_load_dn_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Load has priority; otherwise count down and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ehgu_clk2phase_ctrl.sv
// Two-phase non-overlapping clock generator.
// Optional build macro EHGU_CLK2PHASE_CTRL_STATS_EN adds a saturating
// 32-bit period counter output (period_cnt).
//
// state  | meaning
// IDLE   | stopped, waiting for en
// P0     | phase 0 high for hi_eff cycles
// DEAD01 | gap after phase 0, dead_eff cycles
// P1     | phase 1 high for hi_eff cycles
// DEAD10 | gap after phase 1, dead_eff cycles; end of period
//
// Outputs are registered decodes of the state, so they trail the state by
// one cycle. hi/dead are captured only when a period starts.
module ehgu_clk2phase_ctrl
  import ehgu_clk2phase_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter bit ALLOW_ZERO_DEAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] hi_cycles,
  input  logic [CNT_W-1:0] dead_cycles,
  output logic             phi0,
  output logic             phi1,
  output logic             running,
  output logic             period_done
`ifdef EHGU_CLK2PHASE_CTRL_STATS_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  ehgu_c2p_state_t  state;
  ehgu_c2p_state_t  nxt;
  logic [CNT_W-1:0] hi_s;
  logic [CNT_W-1:0] dead_s;
  logic [CNT_W-1:0] hi_in;
  logic [CNT_W-1:0] dead_in;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             zero;
  logic             sample;
  logic             period_end;

  assign hi_in   = CNT_W'(c2p_clamp(C2P_MAX_W'(hi_cycles), 1'b0));
  assign dead_in = CNT_W'(c2p_clamp(C2P_MAX_W'(dead_cycles), ALLOW_ZERO_DEAD));

  ehgu_load_dn_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .zero     (zero)
  );

  // Next state and counter reload; a zero dead count skips the DEAD states.
  always_comb begin
    nxt        = state;
    load       = 1'b0;
    load_val   = '0;
    sample     = 1'b0;
    period_end = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          nxt      = P0;
          load     = 1'b1;
          load_val = hi_in - CNT_W'(1);
          sample   = 1'b1;
        end
      end
      P0: begin
        if (zero) begin
          load = 1'b1;
          if (dead_s == '0) begin
            nxt      = P1;
            load_val = hi_s - CNT_W'(1);
          end else begin
            nxt      = DEAD01;
            load_val = dead_s - CNT_W'(1);
          end
        end
      end
      DEAD01: begin
        if (zero) begin
          nxt      = P1;
          load     = 1'b1;
          load_val = hi_s - CNT_W'(1);
        end
      end
      P1: begin
        if (zero) begin
          if (dead_s != '0) begin
            nxt      = DEAD10;
            load     = 1'b1;
            load_val = dead_s - CNT_W'(1);
          end else begin
            period_end = 1'b1;
            if (en) begin
              nxt      = P0;
              load     = 1'b1;
              load_val = hi_in - CNT_W'(1);
              sample   = 1'b1;
            end else begin
              nxt = IDLE;
            end
          end
        end
      end
      DEAD10: begin
        if (zero) begin
          period_end = 1'b1;
          if (en) begin
            nxt      = P0;
            load     = 1'b1;
            load_val = hi_in - CNT_W'(1);
            sample   = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State, captured configuration and registered phase outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hi_s        <= '0;
      dead_s      <= '0;
      phi0        <= 1'b0;
      phi1        <= 1'b0;
      running     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state <= nxt;
      if (sample) begin
        hi_s   <= hi_in;
        dead_s <= dead_in;
      end
      phi0        <= (state == P0);
      phi1        <= (state == P1);
      running     <= (state != IDLE);
      period_done <= period_end;
    end
  end

`ifdef EHGU_CLK2PHASE_CTRL_STATS_EN
  // Saturating count of completed periods, in step with period_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (period_end && (period_cnt != '1)) begin
      period_cnt <= period_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ehgu_clk2phase_ctrl.sv
// Directed bench for ehgu_clk2phase_ctrl: a default instance and one with
// zero dead time allowed, both driven from the same inputs.
module tb_ehgu_clk2phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] hi  = 8'd0;
  logic [7:0] dead = 8'd0;
  logic       phi0_d, phi1_d, run_d, pd_d;
  logic       phi0_z, phi1_z, run_z, pd_z;
`ifdef EHGU_CLK2PHASE_CTRL_STATS_EN
  logic [31:0] pcnt_d, pcnt_z;
`endif
  logic       sel = 1'b0;
  logic       s_phi0, s_phi1, s_pd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ehgu_clk2phase_ctrl #(.CNT_W(8), .ALLOW_ZERO_DEAD(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .hi_cycles(hi), .dead_cycles(dead),
    .phi0(phi0_d), .phi1(phi1_d), .running(run_d), .period_done(pd_d)
`ifdef EHGU_CLK2PHASE_CTRL_STATS_EN
    , .period_cnt(pcnt_d)
`endif
  );

  ehgu_clk2phase_ctrl #(.CNT_W(8), .ALLOW_ZERO_DEAD(1'b1)) u_dutz (
    .clk(clk), .rst(rst), .en(en), .hi_cycles(hi), .dead_cycles(dead),
    .phi0(phi0_z), .phi1(phi1_z), .running(run_z), .period_done(pd_z)
`ifdef EHGU_CLK2PHASE_CTRL_STATS_EN
    , .period_cnt(pcnt_z)
`endif
  );

  assign s_phi0 = sel ? phi0_z : phi0_d;
  assign s_phi1 = sel ? phi1_z : phi1_d;
  assign s_pd   = sel ? pd_z   : pd_d;

  // Continuous non-overlap watch on both instances.
  always @(negedge clk) begin
    if ((phi0_d && phi1_d) || (phi0_z && phi1_z)) begin
      n_bad++;
      $display("FAIL overlap t=%0t phi0/phi1 both high (d=%b%b z=%b%b) required not both", $time,
               phi0_d, phi1_d, phi0_z, phi1_z);
    end
  end

  typedef struct {
    logic       zd;
    logic [7:0] hi;
    logic [7:0] dead;
    int         per;
    int         hlen;
    int         gap;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts negedges until the selected phi0 shows a rising edge.
  task automatic wait_rise(input int bound, output int n, output bit ok);
    logic prev;
    prev = s_phi0;
    n  = 0;
    ok = 1'b0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (s_phi0 && !prev) begin
        ok = 1'b1;
        return;
      end
      prev = s_phi0;
    end
  endtask

  initial begin
    int  n, n2, c, p0c, p1c, gapc, pdc, runc;
    bit  ok;
    logic prev;

    vecs[0] = '{1'b0, 8'd3,   8'd2,   10,   3,   4};
    vecs[1] = '{1'b0, 8'd0,   8'd0,   4,    1,   2};
    vecs[2] = '{1'b0, 8'd1,   8'd1,   4,    1,   2};
    vecs[3] = '{1'b0, 8'd5,   8'd0,   12,   5,   2};
    vecs[4] = '{1'b0, 8'd2,   8'd7,   18,   2,   14};
    vecs[5] = '{1'b0, 8'd255, 8'd255, 1020, 255, 510};
    vecs[6] = '{1'b1, 8'd3,   8'd0,   6,    3,   0};
    vecs[7] = '{1'b1, 8'd0,   8'd0,   2,    1,   0};
    vecs[8] = '{1'b1, 8'd4,   8'd2,   12,   4,   4};

    // Reset values and idle behaviour with en low.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_phi0", int'(phi0_d), 0);
    check("rst_phi1", int'(phi1_d), 0);
    check("rst_running", int'(run_d), 0);
    check("rst_period_done", int'(pd_d), 0);
    @(negedge clk);
    rst = 1'b0;
    runc = 0;
    p0c  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      runc += int'(run_d);
      p0c  += int'(phi0_d);
    end
    check("idle_running_cycles", runc, 0);
    check("idle_phi0_cycles", p0c, 0);

    // Steady-state period table, en held high.
    foreach (vecs[v]) begin
      en   = 1'b0;
      sel  = vecs[v].zd;
      hi   = vecs[v].hi;
      dead = vecs[v].dead;
      do_reset();
      en = 1'b1;
      wait_rise(50, n, ok);
      check($sformatf("v%0d_first_rise", v), int'(ok), 1);
      if (ok) begin
        p0c  = 1;
        p1c  = int'(s_phi1);
        gapc = 0;
        pdc  = int'(s_pd);
        c    = 1;
        prev = 1'b1;
        while (c < 2000) begin
          @(negedge clk);
          if (s_phi0 && !prev) break;
          p0c  += int'(s_phi0);
          p1c  += int'(s_phi1);
          gapc += int'(!s_phi0 && !s_phi1);
          pdc  += int'(s_pd);
          prev = s_phi0;
          c++;
        end
        check($sformatf("v%0d_period", v), c, vecs[v].per);
        check($sformatf("v%0d_phi0_high", v), p0c, vecs[v].hlen);
        check($sformatf("v%0d_phi1_high", v), p1c, vecs[v].hlen);
        check($sformatf("v%0d_gap", v), gapc, vecs[v].gap);
        check($sformatf("v%0d_period_done", v), pdc, 1);
      end
    end
    en  = 1'b0;
    sel = 1'b0;

    // en dropped in the second phi0 cycle: period completes, then idle.
    hi = 8'd4;
    dead = 8'd1;
    do_reset();
    en = 1'b1;
    wait_rise(50, n, ok);
    check("drop_first_rise", int'(ok), 1);
    p0c = 1; p1c = 0; pdc = 0; runc = 1;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) en = 1'b0;
      p0c  += int'(phi0_d);
      p1c  += int'(phi1_d);
      pdc  += int'(pd_d);
      runc += int'(run_d);
    end
    check("drop_phi0_cycles", p0c, 4);
    check("drop_phi1_cycles", p1c, 4);
    check("drop_period_done", pdc, 1);
    check("drop_running_cycles", runc, 10);
    check("drop_running_end", int'(run_d), 0);

    // hi changed mid-P1: current period unchanged, next period uses new value.
    hi = 8'd3;
    dead = 8'd2;
    do_reset();
    en = 1'b1;
    wait_rise(50, n, ok);
    check("chg_first_rise", int'(ok), 1);
    c = 0;
    while (!phi1_d && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("chg_phi1_seen", int'(phi1_d), 1);
    hi = 8'd5;
    wait_rise(100, n, ok);
    check("chg_period1", c + n, 10);
    wait_rise(100, n2, ok);
    check("chg_period2", n2, 14);
    hi = 8'd3;

    // Reset mid-P1 clears outputs at once; restart latency afterwards.
    c = 0;
    while (!phi1_d && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("rst_mid_phi1_seen", int'(phi1_d), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_phi1", int'(phi1_d), 0);
    check("rst_mid_running", int'(run_d), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_phi0_edge1", int'(phi0_d), 0);
    @(negedge clk);
    check("restart_phi0_edge2", int'(phi0_d), 1);

`ifdef EHGU_CLK2PHASE_CTRL_STATS_EN
    // Twenty periods counted by the stats counter.
    hi = 8'd1;
    dead = 8'd1;
    en = 1'b0;
    do_reset();
    en = 1'b1;
    pdc = 0;
    c = 0;
    while (pdc < 20 && c < 400) begin
      @(negedge clk);
      pdc += int'(pd_d);
      c++;
    end
    en = 1'b0;
    check("stats_pulses", pdc, 20);
    check("stats_period_cnt", int'(pcnt_d), 20);
`endif

    en = 1'b0;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
